// File: rtl/vsa_pkg.sv
// Shared VSA definitions: datapath widths used by both the CPU and the data memory,
// plus the write-buffer entry layout.
package vsa_pkg;

  localparam int unsigned VSA_AW = 5;
  localparam int unsigned VSA_DW = 5;

  typedef struct packed {
    logic [VSA_AW-1:0] addr;
    logic [VSA_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/vsa_dmem_if.sv
// CPU memory-stage bus into vsa_dmem: address, store data/strobe, drain slot, and the
// load data / status returned to the CPU side.
interface vsa_dmem_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = vsa_pkg::VSA_AW,
  parameter int unsigned DW    = vsa_pkg::VSA_DW
);

  logic [AW-1:0]           addr;
  logic [DW-1:0]           wdata;
  logic                    wr;
  logic                    drain_en;
  logic [DW-1:0]           rdata;
  logic [$clog2(DEPTH):0]  wb_count;
  logic                    ovf;

  modport master (
    output addr, wdata, wr, drain_en,
    input  rdata, wb_count, ovf
  );

  modport slave (
    input  addr, wdata, wr, drain_en,
    output rdata, wb_count, ovf
  );

endinterface

// File: rtl/vsa_wbuf.sv
// Circular store buffer with youngest-match associative lookup.
// The lookup is only built when VSA_DMEM_FWD_EN is defined.
module vsa_wbuf
  import vsa_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_wr,
  input  wb_entry_t         i_wentry,
  input  logic              i_drain_en,
  input  logic [VSA_AW-1:0] i_lookup_addr,
  output logic              o_hit,
  output logic [VSA_DW-1:0] o_hit_data,
  output wb_entry_t         o_head,
  output logic              o_drain,
  output logic              o_drop,
  output logic [CW-1:0]     o_count,
  output logic              o_full
);

  wb_entry_t       r_entries [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic            w_full;
  logic            w_drain;
  logic            w_enq;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_drain = i_drain_en && (r_count != '0);
  // A drain in the same cycle frees the slot a full buffer needs.
  assign w_enq   = i_wr && (!w_full || w_drain);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_entries[r_tail] <= i_wentry;
        r_tail            <= r_tail + PW'(1);
      end
      if (w_drain) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef VSA_DMEM_FWD_EN
  // Scan oldest to youngest so the last match found is the youngest store.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < r_count) && (r_entries[r_head + PW'(k)].addr == i_lookup_addr)) begin
        o_hit      = 1'b1;
        o_hit_data = r_entries[r_head + PW'(k)].data;
      end
    end
  end
`else
  logic w_unused_lookup;
  assign w_unused_lookup = ^i_lookup_addr;
  assign o_hit           = 1'b0;
  assign o_hit_data      = '0;
`endif

  assign o_head  = r_entries[r_head];
  assign o_drain = w_drain;
  assign o_drop  = i_wr && !w_enq;
  assign o_count = r_count;
  assign o_full  = w_full;

endmodule

// File: rtl/vsa_dmem.sv
// VSA data memory: buffered stores draining into a 32x5 array, combinational loads.
// Define VSA_DMEM_FWD_EN to forward loads from buffered stores.
module vsa_dmem
  import vsa_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = VSA_AW,
  parameter int unsigned DW    = VSA_DW
) (
  input  logic       clock,
  input  logic       reset,
  vsa_dmem_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [DW-1:0]  r_mem [2**AW];
  logic           r_ovf;

  wb_entry_t      w_wentry;
  wb_entry_t      w_head;
  logic           w_hit;
  logic [DW-1:0]  w_hit_data;
  logic           w_drain;
  logic           w_drop;
  logic [CW-1:0]  w_count;
  logic           w_full;

  assign w_wentry.addr = bus.addr;
  assign w_wentry.data = bus.wdata;

  vsa_wbuf #(
    .DEPTH (DEPTH)
  ) u_wbuf (
    .clock         (clock),
    .reset         (reset),
    .i_wr          (bus.wr),
    .i_wentry      (w_wentry),
    .i_drain_en    (bus.drain_en),
    .i_lookup_addr (bus.addr),
    .o_hit         (w_hit),
    .o_hit_data    (w_hit_data),
    .o_head        (w_head),
    .o_drain       (w_drain),
    .o_drop        (w_drop),
    .o_count       (w_count),
    .o_full        (w_full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2**AW; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_drain) begin
      r_mem[w_head.addr] <= w_head.data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

`ifdef VSA_DMEM_FWD_EN
  logic w_unused_full;
  assign w_unused_full = w_full;
  assign bus.rdata     = w_hit ? w_hit_data : r_mem[bus.addr];
`else
  logic w_unused_fwd;
  assign w_unused_fwd = w_hit ^ (^w_hit_data) ^ w_full;
  assign bus.rdata    = r_mem[bus.addr];
`endif

  assign bus.wb_count = w_count;
  assign bus.ovf      = r_ovf;

endmodule

// File: tb/tb_vsa_dmem.sv
// Directed bench for vsa_dmem: vector table for buffer/forwarding behaviour plus
// sequences for overflow, full-with-drain, reset discard and a CPU-style SW/LW pair.
module tb_vsa_dmem;
  import vsa_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef VSA_DMEM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  vsa_dmem_if #(.DEPTH(DEPTH), .AW(VSA_AW), .DW(VSA_DW)) bus ();

  vsa_dmem #(.DEPTH(DEPTH), .AW(VSA_AW), .DW(VSA_DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0] a;
    logic [4:0] d;
    logic       w;
    logic       de;
    logic [4:0] e_fwd;
    logic [4:0] e_nofwd;
    int         e_cnt;
    logic       e_ovf;
  } vec_t;

  vec_t vecs [14];
  int   n_checks = 0;
  int   n_errs   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [4:0] a, input logic [4:0] d, input logic w,
                       input logic de);
    bus.addr     = a;
    bus.wdata    = d;
    bus.wr       = w;
    bus.drain_en = de;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      drive(5'(a), 5'd0, 1'b0, 1'b1);
      #1;
      chk($sformatf("%s rdata[%0d]", tag, a), int'(bus.rdata), 0);
      tick();
    end
  endtask

  logic [4:0] r1;
  logic [4:0] r2;

  initial begin
    // Values checked in each row reflect state before that row's clock edge.
    vecs[0]  = '{5'd3, 5'h0A, 1'b1, 1'b0, 5'h00, 5'h00, 0, 1'b0};
    vecs[1]  = '{5'd3, 5'h00, 1'b0, 1'b0, 5'h0A, 5'h00, 1, 1'b0};
    vecs[2]  = '{5'd9, 5'h01, 1'b1, 1'b0, 5'h00, 5'h00, 1, 1'b0};
    vecs[3]  = '{5'd9, 5'h07, 1'b1, 1'b0, 5'h01, 5'h00, 2, 1'b0};
    vecs[4]  = '{5'd9, 5'h00, 1'b0, 1'b0, 5'h07, 5'h00, 3, 1'b0};
    vecs[5]  = '{5'd3, 5'h00, 1'b0, 1'b1, 5'h0A, 5'h00, 3, 1'b0};
    vecs[6]  = '{5'd3, 5'h00, 1'b0, 1'b1, 5'h0A, 5'h0A, 2, 1'b0};
    vecs[7]  = '{5'd9, 5'h00, 1'b0, 1'b0, 5'h07, 5'h01, 1, 1'b0};
    vecs[8]  = '{5'd9, 5'h00, 1'b0, 1'b1, 5'h07, 5'h01, 1, 1'b0};
    vecs[9]  = '{5'd9, 5'h00, 1'b0, 1'b1, 5'h07, 5'h07, 0, 1'b0};
    vecs[10] = '{5'd9, 5'h02, 1'b1, 1'b1, 5'h07, 5'h07, 0, 1'b0};
    vecs[11] = '{5'd9, 5'h00, 1'b0, 1'b0, 5'h02, 5'h07, 1, 1'b0};
    vecs[12] = '{5'd9, 5'h03, 1'b1, 1'b1, 5'h02, 5'h07, 1, 1'b0};
    vecs[13] = '{5'd9, 5'h00, 1'b0, 1'b0, 5'h03, 5'h02, 1, 1'b0};

    #1;
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("reset wb_count", int'(bus.wb_count), 0);
    chk("reset ovf", int'(bus.ovf), 0);
    read_all_zero("reset");

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].a, vecs[i].d, vecs[i].w, vecs[i].de);
      #1;
      chk($sformatf("vec%0d rdata", i), int'(bus.rdata),
          int'(FWD ? vecs[i].e_fwd : vecs[i].e_nofwd));
      chk($sformatf("vec%0d wb_count", i), int'(bus.wb_count), vecs[i].e_cnt);
      chk($sformatf("vec%0d ovf", i), int'(bus.ovf), int'(vecs[i].e_ovf));
      tick();
    end

    // Overflow: DEPTH+1 stores with no drain, last one dropped.
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      drive(5'(10 + i), 5'(i + 1), 1'b1, 1'b0);
      tick();
    end
    drive(5'(10 + DEPTH), 5'd0, 1'b0, 1'b0);
    #1;
    chk("ovf wb_count", int'(bus.wb_count), DEPTH);
    chk("ovf flag", int'(bus.ovf), 1);
    chk("ovf dropped rdata", int'(bus.rdata), 0);
    bus.addr = 5'd10;
    #1;
    chk("ovf oldest rdata", int'(bus.rdata), FWD ? 1 : 0);
    bus.addr = 5'(10 + DEPTH - 1);
    #1;
    chk("ovf youngest rdata", int'(bus.rdata), FWD ? DEPTH : 0);
    drive(5'd0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) tick();
    drive(5'd10, 5'd0, 1'b0, 1'b0);
    #1;
    chk("ovf drained wb_count", int'(bus.wb_count), 0);
    chk("ovf sticky", int'(bus.ovf), 1);
    chk("ovf drained rdata", int'(bus.rdata), 1);
    bus.addr = 5'(10 + DEPTH);
    #1;
    chk("ovf dropped never stored", int'(bus.rdata), 0);
    tick();

    // Full buffer with a drain on the store cycle: store accepted.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(5'(10 + i), 5'(i + 1), 1'b1, 1'b0);
      tick();
    end
    drive(5'(10 + DEPTH), 5'(DEPTH + 1), 1'b1, 1'b1);
    #1;
    chk("full pre wb_count", int'(bus.wb_count), DEPTH);
    tick();
    drive(5'd10, 5'd0, 1'b0, 1'b0);
    #1;
    chk("full+drain wb_count", int'(bus.wb_count), DEPTH);
    chk("full+drain ovf", int'(bus.ovf), 0);
    chk("full+drain head in array", int'(bus.rdata), 1);
    bus.addr = 5'(10 + DEPTH);
    #1;
    chk("full+drain accepted rdata", int'(bus.rdata), FWD ? DEPTH + 1 : 0);
    tick();

    // Reset with stores pending discards them and clears the array.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(5'(20 + i), 5'(11 + i), 1'b1, 1'b0);
      tick();
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("pending wb_count", int'(bus.wb_count), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midreset wb_count", int'(bus.wb_count), 0);
    chk("midreset ovf", int'(bus.ovf), 0);
    read_all_zero("midreset");
    drive(5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("midreset no drain", int'(bus.wb_count), 0);

    // CPU-style SW R1 -> [4]; LW [4] -> R2.
    do_reset();
    for (int it = 0; it < 8; it++) begin
      r1 = 5'($urandom_range(0, 31));
      drive(5'd4, r1, 1'b1, 1'($urandom_range(0, 1)));
      tick();
      if (FWD) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          drive(5'd0, 5'd0, 1'b0, 1'($urandom_range(0, 1)));
          tick();
        end
      end else begin
        for (int g = 0; g < 4; g++) begin
          drive(5'd0, 5'd0, 1'b0, 1'b1);
          tick();
        end
      end
      drive(5'd4, 5'd0, 1'b0, 1'($urandom_range(0, 1)));
      #1;
      r2 = bus.rdata;
      chk($sformatf("cpu lw iter%0d", it), int'(r2), int'(r1));
      tick();
      drive(5'd0, 5'd0, 1'b0, 1'b1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
